// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin owner of a 4:1 mux with registered selects/output.
// Define ARB_TIMEOUT_EN to force release after MAX_HOLD grant cycles.
module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 15,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    input  logic       i0,
    input  logic       i1,
    input  logic       i2,
    input  logic       i3,
    output logic [3:0] gnt,
    output logic       s1,
    output logic       s0,
    output logic       busy,
    output logic       out,
    output logic       timeout
);
    typedef enum logic {IDLE, GRANT} state_t;

    if (MAX_HOLD < 1 || MAX_HOLD > 255 || (64'd1 << CNT_W) <= 64'(MAX_HOLD)) begin : g_bad_param
        $error("mux4_rr_arbiter: MAX_HOLD/CNT_W out of range");
    end

    state_t     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d, last_q, last_d, pick, c;
    logic       busy_q, busy_d, out_q, out_d, to_q, to_d, rel, force_rel;
    logic [3:0] din;

    assign din = {i3, i2, i1, i0};
    assign rel = done | ~req[sel_q];

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign force_rel = ~rel && cnt_q == CNT_W'(MAX_HOLD - 1);
`else
    assign force_rel = 1'b0;
`endif

    // Scan downward so the lowest offset from last+1 wins.
    always_comb begin
        pick = last_q;
        c    = '0;
        for (int j = 3; j >= 0; j--) begin
            c = last_q + 2'(j + 1);
            if (req[c]) pick = c;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        last_d  = last_q;
        to_d    = 1'b0;
        out_d   = busy_q ? din[sel_q] : 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        if (state_q == IDLE) begin
            if (|req) begin
                state_d = GRANT;
                gnt_d   = 4'b0001 << pick;
                sel_d   = pick;
                busy_d  = 1'b1;
`ifdef ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
        end else if (rel || force_rel) begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            busy_d  = 1'b0;
            last_d  = sel_q;
            to_d    = force_rel;
        end else begin
`ifdef ARB_TIMEOUT_EN
            cnt_d   = cnt_q + 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            busy_q  <= 1'b0;
            last_q  <= 2'd3;
            out_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
            out_q   <= out_d;
            to_q    <= to_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
    assign timeout = to_q;
`else
    assign timeout = 1'b0;
`endif

    assign gnt  = gnt_q;
    assign s1   = sel_q[1];
    assign s0   = sel_q[0];
    assign busy = busy_q;
    assign out  = out_q;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed checks of grant rotation, release, reset and hold limit.
module tb_mux4_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       done, i0, i1, i2, i3;
    logic [3:0] gnt;
    logic       s1, s0, busy, out, timeout;
    int         n_run = 0;
    int         n_fail = 0;

    mux4_rr_arbiter #(.MAX_HOLD(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .i0(i0), .i1(i1), .i2(i2), .i3(i3),
        .gnt(gnt), .s1(s1), .s0(s0), .busy(busy), .out(out), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_grant(input string tag, input logic [3:0] g, input logic [1:0] s, input logic b);
        chk({tag, "_gnt"}, {4'h0, gnt}, {4'h0, g});
        chk({tag, "_sel"}, {6'h0, s1, s0}, {6'h0, s});
        chk({tag, "_busy"}, {7'h0, busy}, {7'h0, b});
    endtask

    initial begin
        rst_n = 1'b0; req = 4'b0000; done = 1'b0;
        i0 = 1'b0; i1 = 1'b0; i2 = 1'b0; i3 = 1'b0;
        tick(); tick();
        chk_grant("reset", 4'b0000, 2'd0, 1'b0);
        chk("reset_out", {7'h0, out}, 8'h0);
        chk("reset_to", {7'h0, timeout}, 8'h0);
        rst_n = 1'b1;

        // Single request, latency and registered output
        req = 4'b0100; i2 = 1'b1;
        tick();
        chk_grant("req2", 4'b0100, 2'd2, 1'b1);
        chk("req2_out0", {7'h0, out}, 8'h0);
        tick();
        chk("req2_out1", {7'h0, out}, 8'h1);
        req = 4'b0000;
        tick();
        chk_grant("req2_rel", 4'b0000, 2'd2, 1'b0);
        tick();
        chk("req2_out_idle", {7'h0, out}, 8'h0);
        chk_grant("idle_hold", 4'b0000, 2'd2, 1'b0);

        // Rotation with all four requesting
        rst_n = 1'b0; #1; rst_n = 1'b1;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_grant($sformatf("rot%0d", k), 4'b0001 << (k % 4), 2'(k % 4), 1'b1);
            done = 1'b1;
            tick();
            chk_grant($sformatf("rot%0d_rel", k), 4'b0000, 2'(k % 4), 1'b0);
            done = 1'b0;
        end

        // Owner drops request; scan continues past it
        req = 4'b0010;
        tick();
        chk_grant("own1", 4'b0010, 2'd1, 1'b1);
        req = 4'b1001;
        tick();
        chk_grant("own1_drop", 4'b0000, 2'd1, 1'b0);
        tick();
        chk_grant("own3", 4'b1000, 2'd3, 1'b1);

        // Mid-grant asynchronous reset
        i3 = 1'b1;
        tick();
        chk("own3_out", {7'h0, out}, 8'h1);
        rst_n = 1'b0; #1;
        chk_grant("mid_rst", 4'b0000, 2'd0, 1'b0);
        chk("mid_rst_out", {7'h0, out}, 8'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk_grant("post_rst", 4'b0001, 2'd0, 1'b1);

        // done and req drop together form one release
        done = 1'b1; req = 4'b1000;
        tick();
        chk_grant("dual_rel", 4'b0000, 2'd0, 1'b0);
        done = 1'b0;
        tick();
        chk_grant("after_dual", 4'b1000, 2'd3, 1'b1);
        done = 1'b1;
        tick();
        req = 4'b0000;
        tick();
        chk_grant("idle_done", 4'b0000, 2'd3, 1'b0);
        done = 1'b0;

        // Hold limit
        rst_n = 1'b0; #1; rst_n = 1'b1;
        req = 4'b0011;
        tick();
`ifdef ARB_TIMEOUT_EN
        for (int c = 0; c < 4; c++) begin
            if (c > 0) tick();
            chk($sformatf("hold%0d_gnt", c), {4'h0, gnt}, 8'h01);
            chk($sformatf("hold%0d_to", c), {7'h0, timeout}, 8'h0);
        end
        tick();
        chk("to_gnt", {4'h0, gnt}, 8'h00);
        chk("to_pulse", {7'h0, timeout}, 8'h1);
        tick();
        chk("to_next_gnt", {4'h0, gnt}, 8'h02);
        chk("to_clear", {7'h0, timeout}, 8'h0);
`else
        for (int c = 0; c < 50; c++) begin
            chk($sformatf("hold%0d_gnt", c), {4'h0, gnt}, 8'h01);
            chk($sformatf("hold%0d_to", c), {7'h0, timeout}, 8'h0);
            tick();
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
